alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits (>= 4).
REQ-002 Parameter: OPW, default 4, operator field width in bits.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset; active when 0.
REQ-005 in_valid  input  1  request present on operator/op1/op2.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 operator  input  OPW  opcode: 0 ADD, 1 SUB, 2 MUL, 3 NAND, 4 DIV, 5 MOD, 6 LT, 7 LE, others NOP.
REQ-008 op1, op2  input  WIDTH each  unsigned operands.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 out  output  WIDTH  result.
REQ-012 flags  output  4  {DZ, V, C, Z}, bit 3 to bit 0.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 The block SHALL assert in_ready only in IDLE; accept = in_valid && in_ready, at which point operator, op1 and op2 are registered.
REQ-015 For ADD, SUB, NAND, LT, LE and NOP, IDLE SHALL go to DONE on accept; out_valid is high on the first cycle after accept (latency 1).
REQ-016 For MUL, DIV and MOD, IDLE SHALL go to BUSY on accept; BUSY SHALL last exactly WIDTH cycles (one iteration per cycle: shift-add multiply, restoring divide), then go to DONE; out_valid is high on cycle WIDTH+1 after accept.
REQ-017 In DONE, out_valid SHALL be 1 and out/flags SHALL stay stable until out_ready=1; DONE with out_ready=1 SHALL go to IDLE on the next edge, with out_valid=0 in that IDLE cycle.
REQ-018 A new request SHALL NOT be accepted in the DONE-exit cycle; minimum request-to-request spacing is 2 cycles for single-cycle ops.
REQ-019 ADD: out = (op1+op2) mod 2^WIDTH; C = carry out of bit WIDTH-1.
REQ-020 SUB: out = (op1-op2) mod 2^WIDTH; C = 1 iff op1 < op2 (borrow).
REQ-021 MUL: out = low WIDTH bits of the 2*WIDTH-bit product; V = 1 iff the high WIDTH bits are nonzero.
REQ-022 NAND: out = bitwise ~(op1 & op2).
REQ-023 DIV: out = floor(op1/op2); MOD: out = op1 mod op2.
REQ-024 For op2 = 0, DIV SHALL give out = all ones, MOD SHALL give out = op1; DZ = 1, still after the full WIDTH-cycle BUSY.
REQ-025 LT/LE: out = 1 if op1 < op2 (resp. <=), else 0, zero-extended to WIDTH.
REQ-026 Undefined opcodes SHALL give out = 0 and flags = 0b0001 (Z only), with latency 1.
REQ-027 Z SHALL equal (out == 0) for every op; C, V and DZ SHALL be 0 for ops that do not define them.
REQ-028 Input changes while in BUSY or DONE SHALL have no effect on out or flags.
REQ-029 out and flags SHALL hold their last values in IDLE; only out_valid qualifies them.

Reset
REQ-030 rst=0 SHALL, asynchronously and at any state including mid-BUSY, force the FSM to IDLE, out=0, flags=0, out_valid=0 and clear iteration counter and partial results.
REQ-031 During reset in_ready SHALL be 0; in the first cycle after rst rises it SHALL be 1.
REQ-032 An operation aborted by reset SHALL produce no out_valid pulse.

Verification (WIDTH=16)
REQ-033 ADD 0xFFFF+0x0001, out_ready=1 -> out_valid 1 cycle after accept, out=0x0000, flags=0b0011 (C, Z).
REQ-034 MUL 0x0100*0x0100 -> out_valid on cycle 17 after accept, out=0x0000, flags=0b0101 (V, Z); MUL 0x00FF*0x0003 -> 0x02FD, flags=0.
REQ-035 DIV 100/7 -> 0x000E; MOD 100/7 -> 0x0002; DIV 0x1234/0 -> 0xFFFF, flags=0b1000; MOD 0x1234/0 -> 0x1234, DZ=1.
REQ-036 SUB 3-5 with out_ready held 0 for 5 cycles after out_valid -> out=0xFFFE and C=1 stable, in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-037 Reset at cycle 8 of a DIV -> out=0, flags=0, out_valid=0 at once; in_ready=1 one cycle after release; no stale result ever appears.
REQ-038 Opcode 0xA with in_valid=1 -> out=0x0000, flags=0b0001, latency 1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops answer one cycle after accept, MUL/DIV/MOD iterate for WIDTH cycles.
// Valid/ready on both sides; the result is held in DONE until out_ready, and no request is taken outside IDLE.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   operator,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(2);
    localparam logic [OPW-1:0] OP_NAND = OPW'(3);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(4);
    localparam logic [OPW-1:0] OP_MOD  = OPW'(5);
    localparam logic [OPW-1:0] OP_LT   = OPW'(6);
    localparam logic [OPW-1:0] OP_LE   = OPW'(7);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [OPW-1:0]       op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;

    logic                 accept;
    logic                 multi;
    logic                 last_iter;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH-1:0]     sc_out;
    logic                 sc_c;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_nxt;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH:0]       div_sub;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_nxt;
    logic [2*WIDTH-1:0]   iter_nxt;

    logic [WIDTH-1:0]     mc_out;
    logic                 mc_v;
    logic                 mc_dz;

    // in_ready is gated by reset so nothing is offered while reset is held.
    assign in_ready  = (state == IDLE) && rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign multi     = (operator == OP_MUL) || (operator == OP_DIV) || (operator == OP_MOD);
    assign last_iter = (state == BUSY) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = multi ? BUSY : DONE;
            BUSY:    if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign add_sum = {1'b0, op1} + {1'b0, op2};

    always_comb begin
        sc_out = '0;
        sc_c   = 1'b0;
        case (operator)
            OP_ADD: begin
                sc_out = add_sum[WIDTH-1:0];
                sc_c   = add_sum[WIDTH];
            end
            OP_SUB: begin
                sc_out = op1 - op2;
                sc_c   = (op1 < op2);
            end
            OP_NAND: sc_out = ~(op1 & op2);
            OP_LT:   sc_out = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            OP_LE:   sc_out = {{(WIDTH-1){1'b0}}, (op1 <= op2)};
            default: sc_out = '0;
        endcase
    end

    // Shift-add multiply: acc = {partial high, remaining multiplier bits}.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: acc = {remainder, dividend bits still to shift in / quotient}.
    assign div_sh  = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge  = (div_sh >= {1'b0, b_q});
    assign div_sub = div_sh - {1'b0, b_q};
    assign div_nxt = {(div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

    assign iter_nxt = (op_q == OP_MUL) ? mul_nxt : div_nxt;

    always_comb begin
        mc_out = '0;
        mc_v   = 1'b0;
        mc_dz  = 1'b0;
        case (op_q)
            OP_MUL: begin
                mc_out = mul_nxt[WIDTH-1:0];
                mc_v   = |mul_nxt[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                mc_dz  = (b_q == '0);
                mc_out = mc_dz ? '1 : div_nxt[WIDTH-1:0];
            end
            OP_MOD: begin
                mc_dz  = (b_q == '0);
                mc_out = mc_dz ? a_q : div_nxt[2*WIDTH-1:WIDTH];
            end
            default: mc_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            acc   <= '0;
            out   <= '0;
            flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= operator;
                        a_q  <= op1;
                        b_q  <= op2;
                        cnt  <= '0;
                        acc  <= (operator == OP_MUL) ? {{WIDTH{1'b0}}, op2} : {{WIDTH{1'b0}}, op1};
                        if (!multi) begin
                            out   <= sc_out;
                            flags <= {1'b0, 1'b0, sc_c, (sc_out == '0)};
                        end
                    end
                end
                BUSY: begin
                    acc <= iter_nxt;
                    cnt <= last_iter ? '0 : cnt + CW'(1);
                    if (last_iter) begin
                        out   <= mc_out;
                        flags <= {mc_dz, mc_v, 1'b0, (mc_out == '0)};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
